// File: rtl/fht_but_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fht_but_feeder
// Brief    : Operand skew scheduler and credit-controlled result FIFO for a
//            single fht_but butterfly instance.
// Revision : 1.0 - initial release
// ============================================================================
module fht_but_feeder #(
    parameter int D_SIZE     = 16,
    parameter int W_SIZE     = 16,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,

    input  logic              iVALID,
    output logic              oREADY,
    input  logic [D_SIZE-1:0] iX_0,
    input  logic [D_SIZE-1:0] iX_1,
    input  logic [D_SIZE-1:0] iX_2,
    input  logic [W_SIZE-1:0] iSIN,
    input  logic [W_SIZE-1:0] iCOS,

    output logic [D_SIZE-1:0] oBX_0,
    output logic [D_SIZE-1:0] oBX_1,
    output logic [D_SIZE-1:0] oBX_2,
    output logic [W_SIZE-1:0] oBSIN,
    output logic [W_SIZE-1:0] oBCOS,
    input  logic [D_SIZE-1:0] iBY_0,
    input  logic [D_SIZE-1:0] iBY_1,

    output logic              oVALID,
    input  logic              iREADY,
    output logic [D_SIZE-1:0] oY_0,
    output logic [D_SIZE-1:0] oY_1,

    output logic              oBUSY,
    output logic [15:0]       oDONE_CNT
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = $clog2(LAT + FIFO_DEPTH + 1) + 1;

    logic              accept;
    logic              push;
    logic              pop;
    logic [LAT-1:0]    vld_sr;
    logic [LAT-1:0]    vld_sr_nxt;
    logic [D_SIZE-1:0] x0_hold;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic [SUM_W-1:0]  credit_nxt;
    logic              fifo_full;

    logic [D_SIZE-1:0] fifo_y0 [FIFO_DEPTH];
    logic [D_SIZE-1:0] fifo_y1 [FIFO_DEPTH];

    function automatic logic [SUM_W-1:0] popcount(input logic [LAT-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + SUM_W'(v[i]);
        end
        return n;
    endfunction

    assign accept    = iVALID & oREADY;
    assign push      = vld_sr[LAT-1];
    assign oVALID    = (occ != '0);
    assign pop       = oVALID & iREADY;
    assign fifo_full = (occ == OCC_W'(FIFO_DEPTH));
    assign oBUSY     = (vld_sr != '0) | (occ != '0);
    assign oY_0      = fifo_y0[rd_ptr];
    assign oY_1      = fifo_y1[rd_ptr];

    // Credit is evaluated on next-state values and registered, so oREADY
    // reflects state only and never depends combinationally on iVALID/iREADY.
    always_comb begin
        vld_sr_nxt = {vld_sr[LAT-2:0], accept};
        occ_nxt    = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
        credit_nxt = popcount(vld_sr_nxt) + SUM_W'(occ_nxt);
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            vld_sr  <= '0;
            x0_hold <= '0;
            oBX_0   <= '0;
            oBX_1   <= '0;
            oBX_2   <= '0;
            oBSIN   <= '0;
            oBCOS   <= '0;
            oREADY  <= 1'b0;
        end else begin
            vld_sr <= vld_sr_nxt;
            oREADY <= (credit_nxt < SUM_W'(FIFO_DEPTH));
            if (accept) begin
                oBX_1   <= iX_1;
                oBX_2   <= iX_2;
                oBSIN   <= iSIN;
                oBCOS   <= iCOS;
                x0_hold <= iX_0;
            end
            // x0 trails the rest of its packet by exactly one edge.
            if (vld_sr[0]) begin
                oBX_0 <= x0_hold;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            oDONE_CNT <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_y0[i] <= '0;
                fifo_y1[i] <= '0;
            end
        end else begin
            occ <= occ_nxt;
            if (push) begin
                fifo_y0[wr_ptr] <= iBY_0;
                fifo_y1[wr_ptr] <= iBY_1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                oDONE_CNT <= oDONE_CNT + 16'd1;
            end
        end
    end

    a_no_push_when_full : assert property (
        @(posedge iCLK) disable iff (iRESET) !(push && fifo_full)
    );

endmodule
`default_nettype wire
